// File: rtl/prefetch_ar_arbiter.sv
// Two-requester DDR AR arbiter: demand priority, prefetch starvation guard, prefetch
// outstanding limit, one-entry registered output. Optional grant statistics: PRF_ARB_STATS_EN.
module prefetch_ar_arbiter #(
    parameter int unsigned ADDR_BITS       = 16,
    parameter int unsigned TID_WIDTH       = 8,
    parameter int unsigned BURST_LEN_WIDTH = 8,
    parameter int unsigned LOG_QUEUE_SIZE  = 3,
    parameter int unsigned STARVE_WIDTH    = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       d_ar_valid,
    output logic                       d_ar_ready,
    input  logic [ADDR_BITS-1:0]       d_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
    input  logic [TID_WIDTH-1:0]       d_ar_id,
    input  logic                       p_ar_valid,
    output logic                       p_ar_ready,
    input  logic [ADDR_BITS-1:0]       p_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
    input  logic [TID_WIDTH-1:0]       p_ar_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    output logic                       m_ar_is_pr,
    input  logic                       r_done,
    input  logic                       r_done_is_pr,
    input  logic [LOG_QUEUE_SIZE:0]    crs_prOutstandingLimit,
    input  logic [STARVE_WIDTH-1:0]    crs_starveLimit,
    output logic [LOG_QUEUE_SIZE:0]    pr_outstanding,
`ifdef PRF_ARB_STATS_EN
    output logic [15:0]                stat_d_grants,
    output logic [15:0]                stat_p_grants,
`endif
    output logic                       err_underflow
);
    localparam int unsigned CntW = LOG_QUEUE_SIZE + 1;

    logic                       m_valid_q, m_valid_d;
    logic                       m_is_pr_q, m_is_pr_d;
    logic [ADDR_BITS-1:0]       m_addr_q, m_addr_d;
    logic [BURST_LEN_WIDTH-1:0] m_len_q, m_len_d;
    logic [TID_WIDTH-1:0]       m_id_q, m_id_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [STARVE_WIDTH-1:0]    starve_q, starve_d;

    logic            slot_free, p_elig, force_p, can_grant, grant_d, grant_p;
    logic            hs, cnt_inc, cnt_dec;
    logic [CntW:0]   pending;

    always_comb begin
        slot_free = !m_valid_q || m_ar_ready;
        // The held prefetch counts as in flight so the limit can never be overshot.
        pending   = {1'b0, cnt_q} + {{CntW{1'b0}}, m_valid_q && m_is_pr_q};
        p_elig    = p_ar_valid && !flush && (pending < {1'b0, crs_prOutstandingLimit});
        force_p   = (crs_starveLimit != '0) && (starve_q == crs_starveLimit) && p_elig;
        can_grant = resetN && en && slot_free;
        grant_p   = can_grant && (force_p || (!d_ar_valid && p_elig));
        grant_d   = can_grant && !force_p && d_ar_valid;
        hs        = m_valid_q && m_ar_ready;
        cnt_inc   = hs && m_is_pr_q;
        cnt_dec   = r_done && r_done_is_pr;
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_is_pr_d = m_is_pr_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        m_id_d    = m_id_q;
        if (grant_d) begin
            m_valid_d = 1'b1;
            m_is_pr_d = 1'b0;
            m_addr_d  = d_ar_addr;
            m_len_d   = d_ar_len;
            m_id_d    = d_ar_id;
        end else if (grant_p) begin
            m_valid_d = 1'b1;
            m_is_pr_d = 1'b1;
            m_addr_d  = p_ar_addr;
            m_len_d   = p_ar_len;
            m_id_d    = p_ar_id;
        end else if (hs) begin
            m_valid_d = 1'b0;
            m_is_pr_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (cnt_inc && !cnt_dec) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (grant_p) starve_d = '0;
        else if (grant_d && p_elig && starve_q != '1) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_valid_q <= 1'b0;
            m_is_pr_q <= 1'b0;
            m_addr_q  <= '0;
            m_len_q   <= '0;
            m_id_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            starve_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_is_pr_q <= m_is_pr_d;
            m_addr_q  <= m_addr_d;
            m_len_q   <= m_len_d;
            m_id_q    <= m_id_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            starve_q  <= starve_d;
        end
    end

`ifdef PRF_ARB_STATS_EN
    logic [15:0] stat_d_q, stat_p_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stat_d_q <= '0;
            stat_p_q <= '0;
        end else if (hs) begin
            if (m_is_pr_q && stat_p_q != '1)       stat_p_q <= stat_p_q + 1'b1;
            else if (!m_is_pr_q && stat_d_q != '1) stat_d_q <= stat_d_q + 1'b1;
        end
    end

    assign stat_d_grants = stat_d_q;
    assign stat_p_grants = stat_p_q;
`endif

    assign d_ar_ready     = grant_d;
    assign p_ar_ready     = grant_p;
    assign m_ar_valid     = m_valid_q;
    assign m_ar_is_pr     = m_is_pr_q;
    assign m_ar_addr      = m_addr_q;
    assign m_ar_len       = m_len_q;
    assign m_ar_id        = m_id_q;
    assign pr_outstanding = cnt_q;
    assign err_underflow  = err_q;

endmodule
